// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_pkg
//  Description : Shared lane constants, mode encoding and a constant-safe
//                ceil(log2) helper for the streaming population counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package popcount_pkg;

    localparam int LANE_W     = 8;
    localparam int LANE_CNT_W = 4;

    typedef enum logic {
        MODE_BEAT  = 1'b0,
        MODE_FRAME = 1'b1
    } mode_e;

    // Ceiling log2, usable in parameter/localparam expressions
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_lane8.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_lane8
//  Description : Combinational population count of one 8-bit lane (0..8).
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_lane8
    import popcount_pkg::*;
(
    input  logic [LANE_W-1:0]     i_lane,
    output logic [LANE_CNT_W-1:0] o_cnt
);

    // Sum the individual bits of the lane
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < LANE_W; i++) begin
            o_cnt = o_cnt + LANE_CNT_W'(i_lane[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/popcount_stream.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_stream
//  Description : Three-stage streaming population counter with valid/ready
//                on both sides. Mode 0 reports one count per beat; mode 1
//                accumulates (saturating) across beats up to the last flag.
//                Optional build macro POPCOUNT_MASK_EN adds an I_mask input
//                so that only I & I_mask is counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_stream
    import popcount_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ACC_W = 16
)
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_valid,
    output logic             I_ready,
    input  logic [WIDTH-1:0] I,
`ifdef POPCOUNT_MASK_EN
    input  logic [WIDTH-1:0] I_mask,
`endif
    input  logic             I_last,
    input  logic             mode,
    output logic             O_valid,
    input  logic             O_ready,
    output logic [ACC_W-1:0] O,
    output logic             O_sat
);

    localparam int LANES = WIDTH / LANE_W;
    localparam int CNT_W = clog2(WIDTH + 1);
    localparam int SUM_W = ACC_W + 1;

    logic                               w_adv;
    logic [WIDTH-1:0]                   w_data;
    logic [LANES-1:0][LANE_CNT_W-1:0]   w_lane_cnt;
    logic [CNT_W-1:0]                   w_lane_sum;
    logic [SUM_W-1:0]                   w_sum_ext;
    logic                               w_ovf;
    logic [ACC_W-1:0]                   w_sum_sat;
    logic                               w_sat_frame;

    logic                               r_s1_valid;
    logic [LANES-1:0][LANE_CNT_W-1:0]   r_s1_cnt;
    mode_e                              r_s1_mode;
    logic                               r_s1_last;

    logic                               r_s2_valid;
    logic [CNT_W-1:0]                   r_s2_cnt;
    mode_e                              r_s2_mode;
    logic                               r_s2_last;

    logic [ACC_W-1:0]                   r_acc;
    logic                               r_sat_acc;
    logic                               r_o_valid;
    logic [ACC_W-1:0]                   r_o;
    logic                               r_o_sat;

    // The whole pipeline moves as one; a stalled output freezes every stage
    assign w_adv   = !r_o_valid || O_ready;
    assign I_ready = w_adv;

`ifdef POPCOUNT_MASK_EN
    assign w_data = I & I_mask;
`else
    assign w_data = I;
`endif

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            popcount_lane8 u_lane (
                .i_lane (w_data[gi*LANE_W +: LANE_W]),
                .o_cnt  (w_lane_cnt[gi])
            );
        end
    endgenerate

    // S1: capture lane counts together with the beat's mode and last flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_cnt   <= '0;
            r_s1_mode  <= MODE_BEAT;
            r_s1_last  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= I_valid;
            r_s1_cnt   <= w_lane_cnt;
            r_s1_mode  <= mode_e'(mode);
            r_s1_last  <= I_last;
        end
    end

    // Sum the lane counts into the full-word count
    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + CNT_W'(r_s1_cnt[i]);
        end
    end

    // S2: register the word count
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s2_valid <= 1'b0;
            r_s2_cnt   <= '0;
            r_s2_mode  <= MODE_BEAT;
            r_s2_last  <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_cnt   <= w_lane_sum;
            r_s2_mode  <= r_s1_mode;
            r_s2_last  <= r_s1_last;
        end
    end

    // Saturating accumulate: one extra bit detects overflow of the true sum
    always_comb begin
        w_sum_ext   = {1'b0, r_acc} + SUM_W'(r_s2_cnt);
        w_ovf       = w_sum_ext[ACC_W];
        w_sum_sat   = w_ovf ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
        w_sat_frame = r_sat_acc || w_ovf;
    end

    // S3: output register and frame accumulator; mode-0 beats bypass acc
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc     <= '0;
            r_sat_acc <= 1'b0;
            r_o_valid <= 1'b0;
            r_o       <= '0;
            r_o_sat   <= 1'b0;
        end else if (w_adv) begin
            r_o_valid <= 1'b0;
            if (r_s2_valid) begin
                if (r_s2_mode == MODE_BEAT) begin
                    r_o_valid <= 1'b1;
                    r_o       <= ACC_W'(r_s2_cnt);
                    r_o_sat   <= 1'b0;
                end else if (r_s2_last) begin
                    r_o_valid <= 1'b1;
                    r_o       <= w_sum_sat;
                    r_o_sat   <= w_sat_frame;
                    r_acc     <= '0;
                    r_sat_acc <= 1'b0;
                end else begin
                    r_acc     <= w_sum_sat;
                    r_sat_acc <= w_sat_frame;
                end
            end
        end
    end

    assign O_valid = r_o_valid;
    assign O       = r_o;
    assign O_sat   = r_o_sat;

endmodule
`default_nettype wire

// File: doc/popcount_stream.md
Name: popcount_stream

Overview:
Streaming, pipelined population counter. It generalises the fixed 8-bit combinational popcount to a parametrised input width with valid/ready handshakes on both sides. An optional frame-accumulate mode sums counts across beats until a last flag. Sits between packet/bitmap producers and statistics or threshold logic in the datapath.

Parameters:
WIDTH, 32, input word width in bits; multiple of 8, 8..256
ACC_W, 16, accumulator/output width; must be >= clog2(WIDTH+1)
LANES, WIDTH/8, derived; number of 8-bit lane counters (localparam, not overridable)

Ports:
CLK  input  1  clock; all logic on rising edge
RESET  input  1  synchronous active-high reset
I_valid  input  1  input beat valid
I_ready  output  1  block can accept a beat this cycle
I  input  WIDTH  data word to count
I_last  input  1  final beat of frame; ignored in mode 0
mode  input  1  0 = per-beat count, 1 = frame accumulate; sampled with each accepted beat
O_valid  output  1  result valid
O_ready  input  1  downstream accepts result
O  output  ACC_W  count result
O_sat  output  1  result saturated (mode 1 only)

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RESET.
- Reset: all pipeline valids 0, accumulator 0, O = 0, O_valid = 0, O_sat = 0. I_ready reads 1 in the cycle after RESET deasserts. A reset asserted mid-frame discards the partial sum and in-flight beats without emitting them.
- Transfer rules: input beat accepted when I_valid && I_ready. Output consumed when O_valid && O_ready. O, O_sat and O_valid stay stable while O_valid && !O_ready.
- Pipeline: stage S1 registers LANES 4-bit lane counts (0..8 each) plus mode/last. Stage S2 registers the lane-sum tree result, width clog2(WIDTH+1). S3 is the output register holding O, O_sat, O_valid.
- Latency: an accepted beat appears on O exactly 3 cycles later when O_ready is held high.
- Flow control: global enable adv = !O_valid || O_ready. I_ready = adv, combinational from O_ready.
  - When adv = 0 all stages hold.
  - Full throughput is 1 beat/cycle with O_ready high.
  - No bubbles are inserted.
- Mode 0: every beat produces one result. O = zero-extended count. O_sat = 0.
- Mode 1: S2 result is added into acc (ACC_W bits).
  - Non-last beats produce no output, and S3 valid is not set.
  - On the last beat, O = acc + count; acc clears to 0 in the same cycle.
  - Saturating add: if the true sum exceeds 2^ACC_W-1, the sum is clamped. O_sat is sticky for the frame and reported with the last beat.
- Mode change mid-frame: a mode-0 beat arriving while acc != 0 is counted alone. The open mode-1 frame continues with its next mode-1 beat; acc is not disturbed.
- Boundary values:
  - All-ones word gives WIDTH.
  - All-zeros word gives 0.
  - A single-beat frame (I_last on the first beat) in mode 1 equals the mode-0 result.

Optional Feature:
POPCOUNT_MASK_EN:
- When defined, adds input port I_mask (WIDTH). Bits are counted as I & I_mask, with I_mask sampled with the beat.
- When undefined, the port is absent and all bits of I are counted.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package popcount_pkg holds:
  - constants LANE_W = 8 and LANE_CNT_W = 4
  - function clog2
  - enum mode_e {MODE_BEAT = 0, MODE_FRAME = 1}
- Sub-module popcount_lane8 is an 8-bit combinational lane counter, 8 in / 4 out, instantiated LANES times in S1.
- The adder tree and accumulator stay in the top module.

Test Plan:
- Reset: hold RESET 2 cycles mid-stream -> O_valid = 0, O = 0; I_ready = 1 the cycle after release; no stale result emitted.
- Mode 0, WIDTH = 32, O_ready = 1, beats 0x00000000, 0xFFFFFFFF, 0x80000001 on consecutive cycles -> O = 0, 32, 2 on cycles 3, 4, 5 after first acceptance, back-to-back.
- Backpressure: stream 0x0F0F0F0F repeatedly with O_ready toggled randomly -> every result = 16, no drops or duplicates, O stable while stalled, I_ready low exactly when O_valid && !O_ready.
- Mode 1: 3 beats 0xFF, 0xFFFF, 0x1 with I_last on beat 3 -> single result O = 25 after last; acc cleared; next frame of one beat 0x3 -> O = 2.
- Saturation: ACC_W = 6, mode 1, three beats 0xFFFFFFFF with last on the third -> O = 63, O_sat = 1; following frame reports O_sat = 0.
- POPCOUNT_MASK_EN build: I = 0xFFFFFFFF, I_mask = 0x000000F0 -> O = 4; non-mask build with the same I -> O = 32.
